// File: rtl/alu_sequencer_if.sv
// Command/response bus between an issuer (master) and the ALU sequencer (slave).
// Signal names match the original flat port list of alu_sequencer.
interface alu_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_cout;
    logic       rsp_err;
    logic       busy;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_cout, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_cout, rsp_err, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// 8-bit ADD/SUB/XOR/XNOR and 4x4 MUL sequenced through one 4-bit ALU,
// one nibble pass per cycle, with a valid/ready command and response bus.
module four_bit_alu (
    input  logic       i_m,
    input  logic       i_cen,
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [3:0] o_s,
    output logic       o_cout
);
    logic [3:0] w_bx;
    logic [4:0] w_sum;

    // M inverts B and supplies the carry-in; Cen=0 suppresses carries (XOR/XNOR).
    always_comb begin
        w_bx   = i_b ^ {4{i_m}};
        w_sum  = {1'b0, i_a} + {1'b0, w_bx} + {4'b0000, i_m};
        o_s    = i_cen ? w_sum[3:0] : (i_a ^ w_bx);
        o_cout = i_cen & w_sum[4];
    end
endmodule

module alu_sequencer (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_FIX, S_MUL, S_RESP} state_t;
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_XOR  = 3'b010,
        OP_XNOR = 3'b011,
        OP_MUL  = 3'b100
    } op_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [2:0] r_op;
    logic [7:0] r_res;
    logic [3:0] r_q;
    logic [1:0] r_cnt;
    logic       r_clo;
    logic       r_c1;
    logic       r_c2;
    logic       r_err;

    logic       w_alu_m;
    logic       w_alu_cen;
    logic [3:0] w_alu_a;
    logic [3:0] w_alu_b;
    logic [3:0] w_alu_s;
    logic       w_alu_co;
    logic       w_is_add;
    logic       w_is_sub;

    assign w_is_add = (r_op == OP_ADD);
    assign w_is_sub = (r_op == OP_SUB);

    four_bit_alu u_alu (
        .i_m    (w_alu_m),
        .i_cen  (w_alu_cen),
        .i_a    (w_alu_a),
        .i_b    (w_alu_b),
        .o_s    (w_alu_s),
        .o_cout (w_alu_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        bus.cmd_ready = (r_state == S_IDLE);
        bus.busy      = (r_state != S_IDLE);
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        bus.rsp_cout  = 1'b0;
        bus.rsp_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_ADD, OP_SUB, OP_XOR, OP_XNOR: w_next = S_LO;
                        OP_MUL:                          w_next = S_MUL;
                        default:                         w_next = S_RESP;
                    endcase
                end
            end
            S_LO:  w_next = S_HI;
            S_HI: begin
                // The high pass never sees the low carry/borrow; FIX applies it as +/-1.
                if ((w_is_add && r_clo) || (w_is_sub && !r_clo)) w_next = S_FIX;
                else                                            w_next = S_RESP;
            end
            S_FIX: w_next = S_RESP;
            S_MUL: if (r_cnt == 2'd3) w_next = S_RESP;
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = r_res;
                bus.rsp_err   = r_err;
                // r_c2 is cleared at accept, so it only contributes when FIX ran.
                bus.rsp_cout  = (w_is_add & (r_c1 | r_c2)) |
                                (w_is_sub & r_c1 & (r_clo | r_c2));
                if (bus.rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_alu_m   = 1'b0;
        w_alu_cen = 1'b0;
        w_alu_a   = '0;
        w_alu_b   = '0;
        case (r_state)
            S_LO: begin
                w_alu_m   = r_op[0];
                w_alu_cen = ~r_op[1];
                w_alu_a   = r_a[3:0];
                w_alu_b   = r_b[3:0];
            end
            S_HI: begin
                w_alu_m   = r_op[0];
                w_alu_cen = ~r_op[1];
                w_alu_a   = r_a[7:4];
                w_alu_b   = r_b[7:4];
            end
            S_FIX: begin
                w_alu_m   = w_is_sub;
                w_alu_cen = 1'b1;
                w_alu_a   = r_res[7:4];
                w_alu_b   = 4'b0001;
            end
            S_MUL: begin
                w_alu_cen = 1'b1;
                w_alu_a   = r_res[7:4];
                w_alu_b   = r_a[3:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_res <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            r_clo <= 1'b0;
            r_c1  <= 1'b0;
            r_c2  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_a   <= bus.cmd_a;
                        r_b   <= bus.cmd_b;
                        r_op  <= bus.cmd_op;
                        r_res <= '0;
                        r_q   <= bus.cmd_b[3:0];
                        r_cnt <= '0;
                        r_clo <= 1'b0;
                        r_c1  <= 1'b0;
                        r_c2  <= 1'b0;
                        r_err <= (bus.cmd_op > OP_MUL);
                    end
                end
                S_LO: begin
                    r_res[3:0] <= w_alu_s;
                    r_clo      <= w_alu_co;
                end
                S_HI: begin
                    r_res[7:4] <= w_alu_s;
                    r_c1       <= w_alu_co;
                end
                S_FIX: begin
                    r_res[7:4] <= w_alu_s;
                    r_c2       <= w_alu_co;
                end
                S_MUL: begin
                    if (r_q[0]) r_res <= {w_alu_co, w_alu_s, r_res[3:1]};
                    else        r_res <= {1'b0, r_res[7:4], r_res[3:1]};
                    r_q   <= r_q >> 1;
                    r_cnt <= r_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer: results, carries, latency,
// illegal opcodes, backpressure and mid-operation reset.
module tb_alu_sequencer;
    logic clk;
    logic rst_n;
    int unsigned n_checks;
    int unsigned n_pass;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic issue(input string tag, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        check({tag, ".ready"}, {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [7:0] data,
                              input logic cout, input logic err, input int lat_exp);
        int lat;
        lat = 1;
        while (!bus.rsp_valid && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".lat"},  lat, lat_exp);
        check({tag, ".data"}, {24'd0, bus.rsp_data}, {24'd0, data});
        check({tag, ".cout"}, {31'd0, bus.rsp_cout}, {31'd0, cout});
        check({tag, ".err"},  {31'd0, bus.rsp_err},  {31'd0, err});
    endtask

    task automatic ack(input string tag);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check({tag, ".ack_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, ".ack_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] data, input logic cout,
                       input logic err, input int lat_exp);
        issue(tag, op, a, b);
        expect_rsp(tag, data, cout, err, lat_exp);
        ack(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        logic saw_valid;
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst.valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst.busy",  {31'd0, bus.busy},      32'd0);
        check("rst.data",  {24'd0, bus.rsp_data},  32'd0);
        check("rst.cout",  {31'd0, bus.rsp_cout},  32'd0);
        check("rst.err",   {31'd0, bus.rsp_err},   32'd0);
        rst_n = 1'b1;

        run("add_8f_01",  3'b000, 8'h8F, 8'h01, 8'h90, 1'b0, 1'b0, 4);
        run("add_ff_01",  3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 4);
        run("add_12_34",  3'b000, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 3);
        run("sub_10_01",  3'b001, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 4);
        run("sub_00_01",  3'b001, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 4);
        run("sub_35_12",  3'b001, 8'h35, 8'h12, 8'h23, 1'b1, 1'b0, 3);
        run("xor_a5_0f",  3'b010, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0, 3);
        run("xnor_a5_0f", 3'b011, 8'hA5, 8'h0F, 8'h55, 1'b0, 1'b0, 3);
        run("mul_f_f",    3'b100, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 5);
        run("mul_7_0",    3'b100, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0, 5);
        run("mul_93_25",  3'b100, 8'h93, 8'h25, 8'h0F, 1'b0, 1'b0, 5);
        run("ill_111",    3'b111, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1);
        run("after_ill",  3'b000, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 3);

        // Backpressure with an ignored command offered while the response waits.
        issue("bp", 3'b000, 8'h12, 8'h34);
        expect_rsp("bp", 8'h46, 1'b0, 1'b0, 3);
        for (int i = 0; i < 5; i++) begin
            bus.cmd_op    = 3'b001;
            bus.cmd_a     = 8'hFF;
            bus.cmd_b     = 8'h01;
            bus.cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("bp.hold%0d.valid", i), {31'd0, bus.rsp_valid}, 32'd1);
            check($sformatf("bp.hold%0d.data", i),  {24'd0, bus.rsp_data},  32'h46);
            check($sformatf("bp.hold%0d.cout", i),  {31'd0, bus.rsp_cout},  32'd0);
            check($sformatf("bp.hold%0d.ready", i), {31'd0, bus.cmd_ready}, 32'd0);
        end
        bus.cmd_valid = 1'b0;
        ack("bp");
        @(posedge clk);
        #1;
        check("bp.no_ghost_busy",  {31'd0, bus.busy},      32'd0);
        check("bp.no_ghost_valid", {31'd0, bus.rsp_valid}, 32'd0);

        // Reset while in HI of an ADD8 that would otherwise take FIX.
        issue("rsthi", 3'b000, 8'h8F, 8'h01);
        @(posedge clk);
        #1;
        check("rsthi.busy_hi", {31'd0, bus.busy}, 32'd1);
        rst_n         = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b0;
        check("rsthi.ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rsthi.valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rsthi.busy",  {31'd0, bus.busy},      32'd0);
        check("rsthi.data",  {24'd0, bus.rsp_data},  32'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            saw_valid = saw_valid | bus.rsp_valid;
        end
        check("rsthi.no_rsp", {31'd0, saw_valid}, 32'd0);
        run("post_rst", 3'b000, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode: 000 ADD8, 001 SUB8, 010 XOR8, 011 XNOR8, 100 MUL4; 101-111 illegal.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  8  result.
- rsp_cout  out  1  carry/no-borrow flag.
- rsp_err  out  1  illegal opcode flag.
- busy  out  1  state is not IDLE.

Function
REQ-003 The block SHALL instantiate exactly one four_bit_alu, drive its M/Cen/A/B every cycle, and perform all arithmetic only through that instance, one 4-bit pass per cycle.
REQ-004 Command handshake SHALL be cmd_valid&cmd_ready at a clk edge; operands and opcode SHALL be latched at that edge.
REQ-005 cmd_ready SHALL equal (state==IDLE).
REQ-006 States: IDLE, LO, HI, FIX, MUL, RESP.
REQ-007 IDLE transitions on accept: ADD8/SUB8/XOR8/XNOR8 -> LO; MUL4 -> MUL; illegal -> RESP with rsp_err=1, rsp_data=0x00, rsp_cout=0.
REQ-008 ALU controls: ADD M=0,Cen=1; SUB M=1,Cen=1; XOR M=0,Cen=0; XNOR M=1,Cen=0.
REQ-009 In LO the ALU SHALL process nibble [3:0]: store the sum nibble and c_lo.
REQ-010 In HI the ALU SHALL process nibble [7:4]: store the sum nibble and c1.
REQ-011 Leaving HI:
- ADD8 with c_lo=1 -> FIX.
- SUB8 with c_lo=0 -> FIX.
- Otherwise -> RESP.
REQ-012 In FIX the ALU SHALL take A=hi nibble, B=0001, with M=0 for ADD8 and M=1 for SUB8, Cen=1; it SHALL overwrite the hi nibble and store c2, then go to RESP.
REQ-013 rsp_cout SHALL be:
- ADD8: c1|c2 when FIX ran, else c1.
- SUB8: c1&c2 when FIX ran, else c1 (1 = no borrow).
- XOR8/XNOR8/MUL4: 0.
REQ-014 MUL4 SHALL compute cmd_a[3:0]*cmd_b[3:0] as an 8-bit product by shift-add. P=0 and Q=b[3:0] are initialised at accept, followed by 4 MUL cycles, each as follows:
- If Q[0]=1: ALU adds P[7:4]+a[3:0] (M=0, Cen=1), giving carry c and sum s; then P <= {c, s, P[3:1]}.
- If Q[0]=0: P <= {0, P[7:4], P[3:1]}.
- In both cases Q <= Q>>1.
- After the 4th cycle -> RESP.
REQ-015 Latency from accept edge to rsp_valid high SHALL be:
- 3 cycles for logic ops and for ADD8/SUB8 without FIX.
- 4 cycles with FIX.
- 5 cycles for MUL4.
- 1 cycle for illegal opcodes.
REQ-016 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_cout/rsp_err SHALL be held stable until rsp_ready=1; on that edge the state SHALL return to IDLE.
REQ-017 Outside RESP, rsp_valid SHALL be 0. cmd_ready SHALL reassert the cycle after the response handshake, so at most one command is in flight.
REQ-018 cmd_valid while busy SHALL be ignored, with no side effects.

Reset
REQ-019 When rst_n=0 at a clk edge, the following SHALL hold on that edge:
- state=IDLE.
- cmd_ready=1.
- rsp_valid=0, rsp_data=0x00, rsp_cout=0, rsp_err=0.
- busy=0.
- All internal operand, accumulator and carry registers cleared.
REQ-020 Reset mid-operation or in RESP SHALL discard the operation with no response issued. Reset SHALL take priority over every handshake in the same cycle.

Verification
REQ-021 ADD8 0x8F+0x01 -> FIX taken; rsp 0x90, cout=0, 4 cycles. ADD8 0xFF+0x01 -> 0x00, cout=1.
REQ-022 SUB8 0x10-0x01 -> 0x0F, cout=1. SUB8 0x00-0x01 -> 0xFF, cout=0. Both take FIX, 4 cycles. SUB8 0x35-0x12 -> 0x23, cout=1, 3 cycles.
REQ-023 MUL4 a=0xF, b=0xF -> 0xE1, 5 cycles. MUL4 a=0x7, b=0x0 -> 0x00. XNOR8 0xA5,0x0F -> 0x55. XOR8 0xA5,0x0F -> 0xAA; cout=0 for all four.
REQ-024 cmd_op=111 -> rsp_err=1, data=0x00 after 1 cycle. The next command completes with rsp_err=0.
REQ-025 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable and cmd_ready=0 throughout. A new cmd_valid during that time is ignored.
REQ-026 Assert rst_n=0 during HI of ADD8 -> the next cycle is IDLE with cmd_ready=1 and no rsp_valid pulse. A following ADD8 0x01+0x02 -> 0x03.
